clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Parametrised, multi-channel successor to the fixed 50 MHz to 100 Hz divider. It generates NUM_CH independent divided square-wave outputs, plus a one-cycle tick strobe per channel, from the single 50 MHz system clock. Each channel's divide value can be reloaded at runtime, and each channel has its own enable. A global synchronous clear phase-aligns all channels. The block feeds the stopwatch timebase, display multiplexing and debounce sampling, replacing one hard-coded divider per consumer.

## Interface
Parameters:
- NUM_CH, 4, number of independent divider channels (1..16)
- CNT_W, 26, counter and divide-value width in bits
- DEFAULT_DIV, 249999, divide value loaded into every channel at reset (100 Hz square output at 50 MHz)
- CH_IDX_W, 2, width of div_ch; must satisfy 2^CH_IDX_W >= NUM_CH

Ports:
- CLK_50_MHz  input  1  system clock; the only clock in the block
- reset  input  1  asynchronous, active-high reset
- enable  input  NUM_CH  per-channel run enable; bit i gates channel i
- sync_clear  input  1  synchronous clear of all counters and outputs; divide values are kept
- div_load  input  1  single-cycle strobe that writes div_value into channel div_ch
- div_ch  input  CH_IDX_W  target channel index for div_load
- div_value  input  CNT_W  new terminal count for the target channel
- clk_out  output  NUM_CH  divided square waves, registered
- tick  output  NUM_CH  one-cycle strobes, high in the cycle after each clk_out toggle, registered

## Operation
- Each channel holds div_reg[i] and cnt[i], both CNT_W wide, unsigned.
- Terminal condition: cnt[i] >= div_reg[i].
- Enabled, not terminal: cnt[i] <- cnt[i]+1; tick[i] <- 0.
- Enabled, terminal: cnt[i] <- 0; clk_out[i] <- ~clk_out[i]; tick[i] <- 1.
- Resulting rates: half-period = div_reg+1 cycles; clk_out period = 2*(div_reg+1) cycles; tick rate = 2x the clk_out frequency.
- enable[i] low: cnt[i] and clk_out[i] hold; tick[i] <- 0.
- div_load with div_ch < NUM_CH: div_reg[div_ch] <- div_value at the next edge. The counter is not reset.
  - If the running count already meets or exceeds the new value, the channel hits terminal on the following cycle.
  - No cycle is ever lost or stretched beyond the new value.
- div_load with div_ch >= NUM_CH: ignored, with no side effect.
- div_value = 0: clk_out toggles every enabled cycle (25 MHz); tick stays high continuously while enabled.
- sync_clear: all cnt <- 0, clk_out <- 0, tick <- 0. It takes priority over counting and enable.
- sync_clear and div_load in the same cycle: both apply, so the clear happens and the new value is stored.
- reset (async, any time, including mid-count or mid-load): cnt = 0, clk_out = 0, tick = 0, every div_reg = DEFAULT_DIV. The in-flight load is discarded.

## Timing
- All outputs are registered directly from flops. There is no combinational path from any input to any output.
- After reset deasserts with enable high, the first clk_out toggle and tick occur at the (DEFAULT_DIV+1)th rising edge.
- A div_load at edge k is visible in the terminal compare at edge k+1.
- tick is exactly one cycle wide, except in the div_reg = 0 case.
- Re-asserting enable resumes from the held count; there is no extra latency.
- Gating restrictions on outputs:
  - clk_out is a data signal, not a clock. Consumers sample it, or better use tick, in the CLK_50_MHz domain.
  - Neither output is routed to any flop clock pin.

## Structure
- Shared package clock_divider_pkg holds:
  - CLK_HZ = 50_000_000
  - the div_value helper constants DIV_100HZ = 249999, DIV_1KHZ = 24999, DIV_1HZ = 24999999
  - the default CNT_W
- One sub-module, divider_channel, contains one channel's counter, div_reg, clk_out and tick flops.
  - Its inputs are enable, sync_clear, a load strobe, the value and its reset default.
  - The top level instantiates NUM_CH copies through a generate loop and decodes div_ch into per-channel load strobes.

## Test plan
Simulation uses DEFAULT_DIV = 2 and NUM_CH = 4.
- Reset release, enable = 4'b1111: clk_out toggles every 3 cycles (period 6); tick is one-cycle high at cycles 3, 6, 9 after release.
- Load ch1 = 0 and ch2 = 5: ch1 toggles every cycle with tick held high; ch2 settles to period 12; ch0 and ch3 stay unaffected at period 6.
- ch3 at cnt = 4 with div_reg 5, then load 1: ch3 hits terminal on the next cycle and resets to 0, then follows period 4.
- enable[0] low for 7 cycles mid-count: clk_out[0] and the count are frozen and tick[0] = 0; counting resumes from the same count.
- sync_clear pulsed alongside div_load (ch0, 3): all clk_out = 0 and all counts = 0 next cycle; ch0 then toggles every 4 cycles.
- Two further checks:
  - div_ch = 5 on a 4-channel build: ignored.
  - reset asserted mid-period: outputs go 0 immediately (asynchronously) and div_reg returns to 2.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared constants for the clock divider family: system clock rate and
// ready-made divide values for the common 50 MHz timebases.
package clock_divider_pkg;

  localparam int CLK_HZ        = 50_000_000;
  localparam int CNT_W_DEFAULT = 26;

  // Divide value = CLK_HZ / (2 * f_out) - 1 for a square output at f_out.
  localparam int DIV_100HZ = 249999;
  localparam int DIV_1KHZ  = 24999;
  localparam int DIV_1HZ   = 24999999;

endpackage

// File: rtl/divider_channel.sv
// One divider channel: runtime-loadable terminal count, free-running counter,
// registered square-wave output and one-cycle tick strobe.
module divider_channel
  import clock_divider_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             sync_clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic [CNT_W-1:0] div_default_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             terminal;

  // >= rather than == so a freshly loaded smaller value never lets the
  // counter run past it.
  assign terminal = (cnt_q >= div_q);

  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    div_d     = load_i ? value_i : div_q;
    if (sync_clear_i) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
    end else if (enable_i) begin
      if (terminal) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_q     <= div_default_i;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent dividers off CLK_50_MHz; div_ch is decoded into
// per-channel load strobes, out-of-range indices select no channel.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int DEFAULT_DIV = DIV_100HZ,
  parameter int CH_IDX_W    = 2
) (
  input  logic                CLK_50_MHz,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   enable,
  input  logic                sync_clear,
  input  logic                div_load,
  input  logic [CH_IDX_W-1:0] div_ch,
  input  logic [CNT_W-1:0]    div_value,
  output logic [NUM_CH-1:0]   clk_out,
  output logic [NUM_CH-1:0]   tick
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  logic [NUM_CH-1:0] load_ch;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load_ch[i] = div_load && (div_ch == CH_IDX_W'(i));

    divider_channel #(
      .CNT_W(CNT_W)
    ) u_channel (
      .clk_i        (CLK_50_MHz),
      .rst_i        (reset),
      .enable_i     (enable[i]),
      .sync_clear_i (sync_clear),
      .load_i       (load_ch[i]),
      .value_i      (div_value),
      .div_default_i(DIV_RST),
      .clk_out_o    (clk_out[i]),
      .tick_o       (tick[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: reset table, directed corner sequences and
// random traffic checked against a per-channel arithmetic reference model.
module tb_clock_divider_multi;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 2;
  localparam int CH_IDX_W    = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_CH-1:0]   enable;
  logic                sync_clear;
  logic                div_load;
  logic [CH_IDX_W-1:0] div_ch;
  logic [CNT_W-1:0]    div_value;
  logic [NUM_CH-1:0]   clk_out;
  logic [NUM_CH-1:0]   tick;

  clock_divider_multi #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .CH_IDX_W   (CH_IDX_W)
  ) dut (
    .CLK_50_MHz(clk),
    .reset     (rst),
    .enable    (enable),
    .sync_clear(sync_clear),
    .div_load  (div_load),
    .div_ch    (div_ch),
    .div_value (div_value),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt[NUM_CH];
  int m_div[NUM_CH];
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_tick;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0;
      m_div[i] = DEFAULT_DIV;
    end
    m_clk = '0;
    m_tick = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] en, input logic clr, input logic ld,
                            input logic [CH_IDX_W-1:0] ch, input logic [CNT_W-1:0] val);
    for (int i = 0; i < NUM_CH; i++) begin
      m_tick[i] = 1'b0;
      if (clr) begin
        m_cnt[i] = 0;
        m_clk[i] = 1'b0;
      end else if (en[i]) begin
        if (m_cnt[i] >= m_div[i]) begin
          m_cnt[i]  = 0;
          m_clk[i]  = ~m_clk[i];
          m_tick[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (ld && int'(ch) < NUM_CH) m_div[int'(ch)] = int'(val);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [NUM_CH-1:0] en, input logic clr, input logic ld,
                       input logic [CH_IDX_W-1:0] ch, input logic [CNT_W-1:0] val,
                       input string tag);
    enable     = en;
    sync_clear = clr;
    div_load   = ld;
    div_ch     = ch;
    div_value  = val;
    model_step(en, clr, ld, ch, val);
    exp_q.push_back({m_clk, m_tick});
    @(posedge clk);
    #1;
    check(tag, {clk_out, tick}, exp_q.pop_front());
  endtask

  task automatic run(input int n, input logic [NUM_CH-1:0] en);
    for (int k = 0; k < n; k++) cycle(en, 1'b0, 1'b0, '0, '0, "model");
  endtask

  // ---------------- reset-release table ----------------
  typedef struct {
    logic [NUM_CH-1:0] en;
    logic              clr;
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_tick;
  } vec_t;

  vec_t tbl[9];

  task automatic run_table(input string tag);
    for (int v = 0; v < 9; v++) begin
      cycle(tbl[v].en, tbl[v].clr, 1'b0, '0, '0, "tbl_model");
      check(tag, {clk_out, tick}, {tbl[v].exp_clk, tbl[v].exp_tick});
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic hold_clk;
    logic [NUM_CH-1:0] en_r;
    logic clr_r, ld_r;
    logic [CH_IDX_W-1:0] ch_r;
    logic [CNT_W-1:0] val_r;

    // DEFAULT_DIV = 2: toggle and tick on edges 3, 6, 9 after release
    tbl[0] = '{4'hF, 1'b0, 4'h0, 4'h0};
    tbl[1] = '{4'hF, 1'b0, 4'h0, 4'h0};
    tbl[2] = '{4'hF, 1'b0, 4'hF, 4'hF};
    tbl[3] = '{4'hF, 1'b0, 4'hF, 4'h0};
    tbl[4] = '{4'hF, 1'b0, 4'hF, 4'h0};
    tbl[5] = '{4'hF, 1'b0, 4'h0, 4'hF};
    tbl[6] = '{4'hF, 1'b0, 4'h0, 4'h0};
    tbl[7] = '{4'hF, 1'b0, 4'h0, 4'h0};
    tbl[8] = '{4'hF, 1'b0, 4'hF, 4'hF};

    rst = 1'b1;
    enable = '0;
    sync_clear = 1'b0;
    div_load = 1'b0;
    div_ch = '0;
    div_value = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {clk_out, tick}, 8'h00);
    rst = 1'b0;

    run_table("release_table");

    // ch1 -> 0 (toggle every cycle), ch2 -> 5 (period 12)
    cycle(4'hF, 1'b0, 1'b1, 3'd1, 8'd0, "ld_ch1");
    cycle(4'hF, 1'b0, 1'b1, 3'd2, 8'd5, "ld_ch2");
    for (int k = 0; k < 24; k++) begin
      cycle(4'hF, 1'b0, 1'b0, '0, '0, "model");
      check("ch1_tick_held", {7'd0, tick[1]}, 8'd1);
    end

    // ch3: clear + load 5, count to 4, then shrink to 1
    cycle(4'hF, 1'b1, 1'b1, 3'd3, 8'd5, "clr_ld3");
    check("clear_all", {clk_out, tick}, 8'h00);
    run(4, 4'hF);
    cycle(4'hF, 1'b0, 1'b1, 3'd3, 8'd1, "ld3_shrink");
    check("ch3_no_term_yet", {6'd0, clk_out[3], tick[3]}, 8'd0);
    run(1, 4'hF);
    check("ch3_shrink_term", {6'd0, clk_out[3], tick[3]}, 8'd3);
    run(1, 4'hF);
    check("ch3_p4_a", {6'd0, clk_out[3], tick[3]}, 8'd2);
    run(1, 4'hF);
    check("ch3_p4_b", {6'd0, clk_out[3], tick[3]}, 8'd1);

    // enable[0] low for 7 cycles
    run(2, 4'hF);
    hold_clk = m_clk[0];
    for (int k = 0; k < 7; k++) begin
      cycle(4'hE, 1'b0, 1'b0, '0, '0, "model");
      check("ch0_frozen", {6'd0, clk_out[0], tick[0]}, {6'd0, hold_clk, 1'b0});
    end
    run(10, 4'hF);

    // sync_clear together with load ch0 = 3
    cycle(4'hF, 1'b1, 1'b1, 3'd0, 8'd3, "clr_ld0");
    check("clear_all2", {clk_out, tick}, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'hF, 1'b0, 1'b0, '0, '0, "model");
      check("ch0_div3", {6'd0, clk_out[0], tick[0]},
            {6'd0, logic'((k / 4) % 2), logic'(k % 4 == 0)});
    end

    // out-of-range channel index
    cycle(4'hF, 1'b0, 1'b1, 3'd5, 8'd0, "ld_bad_ch");
    run(12, 4'hF);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      en_r  = NUM_CH'($urandom);
      clr_r = ($urandom_range(0, 19) == 0);
      ld_r  = ($urandom_range(0, 5) == 0);
      ch_r  = CH_IDX_W'($urandom_range(0, 7));
      val_r = CNT_W'($urandom_range(0, 7));
      cycle(en_r, clr_r, ld_r, ch_r, val_r, "random");
    end

    // async reset mid-period with a load in flight
    cycle(4'hF, 1'b1, 1'b0, '0, '0, "pre_rst_clr");
    run(3, 4'hF);
    check("pre_rst_active", {7'd0, |clk_out}, 8'd1);
    #2;
    div_load = 1'b1;
    div_ch = 3'd0;
    div_value = 8'd7;
    rst = 1'b1;
    #1;
    check("async_reset", {clk_out, tick}, 8'h00);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    div_load = 1'b0;
    rst = 1'b0;
    run_table("post_reset_table");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
